// File: rtl/rdata_router.sv
// rdata_router: N-slave read-data return router for the core data bus.
// Picks one slave's read data from the active-low chip selects sampled at
// request time, tracking per-slave return latency (0 = same cycle,
// 1 = next cycle) with a one-deep tag pipeline.
// Optional build macro: RDATA_ROUTER_OUT_REG_EN registers rd_valid/rd_data
// (every response then arrives one cycle later; resp_cnt follows the
// registered rd_valid).
//
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// while req_ready is low the core holds req_valid, cs_n and its address
// stable. rd_valid is a single-cycle pulse with no back-pressure; rd_data
// is zero whenever rd_valid is low.
module rdata_router #(
   parameter int                 NUM_SLV  = 3,
   parameter int                 DW       = 32,
   parameter logic [NUM_SLV-1:0] LAT_MASK = 3'b110,
   parameter int                 CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [NUM_SLV-1:0]    cs_n,
   input  logic [NUM_SLV*DW-1:0] slv_rdata,
   output logic                  rd_valid,
   output logic [DW-1:0]         rd_data,
   output logic                  multi_sel_err,
   input  logic                  err_clr,
   output logic [CNT_W-1:0]      resp_cnt
);

   localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   logic [NUM_SLV-1:0] cs_act;
   logic [SEL_W-1:0]   sel;
   logic [SEL_W-1:0]   p1_sel;
   logic               p1_vld;
   logic               sel_lat;
   logic               accept;
   logic               multi_hit;
   logic               rv_c;
   logic [DW-1:0]      sel_data;
   logic [DW-1:0]      p1_data;
   logic [DW-1:0]      rdata_c;

   // Chip selects only matter with req_valid; masking here keeps X on an
   // idle bus away from every downstream decode.
   assign cs_act    = req_valid ? ~cs_n : '0;
   assign multi_hit = |(cs_act & (cs_act - NUM_SLV'(1)));

   // Priority decode: lowest asserted select wins, default slave 0.
   always_comb begin
      sel = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (cs_act[i]) sel = SEL_W'(i);
      end
   end

   // Data and latency muxes for the decoded slave and the pipelined tag.
   always_comb begin
      sel_data = '0;
      p1_data  = '0;
      sel_lat  = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_data = slv_rdata[i*DW +: DW];
            sel_lat  = LAT_MASK[i];
         end
         if (p1_sel == SEL_W'(i)) p1_data = slv_rdata[i*DW +: DW];
      end
   end

   // A latency-0 request must wait while a pipelined response owns the
   // return path; latency-1 requests never conflict and always go through.
   assign req_ready = ~(p1_vld & ~sel_lat);
   assign accept    = req_valid & req_ready;

   // Return-path selection: pipelined response first, then same-cycle data.
   always_comb begin
      rv_c    = ~rst & (p1_vld | (accept & ~sel_lat));
      rdata_c = '0;
      if (rv_c) rdata_c = p1_vld ? p1_data : sel_data;
   end

   // One-deep tag pipeline for latency-1 slaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_vld <= 1'b0;
         p1_sel <= '0;
      end else begin
         p1_vld <= accept & sel_lat;
         if (accept & sel_lat) p1_sel <= sel;
      end
   end

   // Sticky multi-select flag; a new set beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) multi_sel_err <= 1'b0;
      else     multi_sel_err <= multi_hit | (multi_sel_err & ~err_clr);
   end

`ifdef RDATA_ROUTER_OUT_REG_EN
   // Output register for timing closure; adds one cycle to every response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rv_c;
         rd_data  <= rdata_c;
      end
   end
`else
   assign rd_valid = rv_c;
   assign rd_data  = rdata_c;
`endif

   // Delivered-response counter; wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           resp_cnt <= '0;
      else if (rd_valid) resp_cnt <= resp_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_rdata_router.sv
// tb_rdata_router: table-driven directed test of rdata_router (default
// build), plus a hand-written mid-operation reset sequence.
module tb_rdata_router;

   localparam int NUM_SLV = 3;
   localparam int DW      = 32;
   localparam int CNT_W   = 16;

   logic                  clk;
   logic                  rst;
   logic                  req_valid;
   logic                  req_ready;
   logic [NUM_SLV-1:0]    cs_n;
   logic [NUM_SLV*DW-1:0] slv_rdata;
   logic                  rd_valid;
   logic [DW-1:0]         rd_data;
   logic                  multi_sel_err;
   logic                  err_clr;
   logic [CNT_W-1:0]      resp_cnt;

   int checks;
   int failures;

   rdata_router #(
      .NUM_SLV (NUM_SLV),
      .DW      (DW),
      .LAT_MASK(3'b110),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .cs_n         (cs_n),
      .slv_rdata    (slv_rdata),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .multi_sel_err(multi_sel_err),
      .err_clr      (err_clr),
      .resp_cnt     (resp_cnt)
   );

   // Clock: 10 ns period, rising edges at 5, 15, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rv;
      logic [2:0]  cs_n;
      logic        clr;
      logic        e_ready;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_err;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Slave k drives {k-tag, row} so every returned word identifies its source
   // slave (A/B/C = slave 0/1/2) and the cycle it was sampled in.
   task automatic drive_data(input int row);
      slv_rdata = {32'hC000_0000 | 32'(row), 32'hB000_0000 | 32'(row), 32'hA000_0000 | 32'(row)};
   endtask

   task automatic set_vec(input int i, input logic rv, input logic [2:0] c, input logic clr,
                          input logic rdy, input logic vld, input logic [31:0] d,
                          input logic err, input logic [15:0] cnt);
      vecs[i].rv = rv;  vecs[i].cs_n = c;  vecs[i].clr = clr;
      vecs[i].e_ready = rdy; vecs[i].e_vld = vld; vecs[i].e_data = d;
      vecs[i].e_err = err;   vecs[i].e_cnt = cnt;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_valid = 1'b0;
      cs_n      = '1;
      err_clr   = 1'b0;
      drive_data(0);

      //          row rv cs_n    clr  ready vld data          err cnt
      set_vec( 0, 0, 3'bxxx, 0,   1,    0,  32'h0,         0,  0);  // idle, X selects
      set_vec( 1, 1, 3'b110, 0,   1,    1,  32'hA000_0001, 0,  0);  // lat0 slave 0
      set_vec( 2, 1, 3'b101, 0,   1,    0,  32'h0,         0,  1);  // lat1 slave 1
      set_vec( 3, 0, 3'b111, 0,   0,    1,  32'hB000_0003, 0,  1);  // slave 1 returns
      set_vec( 4, 1, 3'b011, 0,   1,    0,  32'h0,         0,  2);  // lat1 slave 2
      set_vec( 5, 1, 3'b110, 0,   0,    1,  32'hC000_0005, 0,  2);  // collision: stall
      set_vec( 6, 1, 3'b110, 0,   1,    1,  32'hA000_0006, 0,  3);  // held req accepted
      set_vec( 7, 1, 3'b101, 0,   1,    0,  32'h0,         0,  4);  // stream s1
      set_vec( 8, 1, 3'b011, 0,   1,    1,  32'hB000_0008, 0,  4);  // stream s2
      set_vec( 9, 1, 3'b101, 0,   1,    1,  32'hC000_0009, 0,  5);  // stream s1
      set_vec(10, 1, 3'b011, 0,   1,    1,  32'hB000_000A, 0,  6);  // stream s2
      set_vec(11, 0, 3'b111, 0,   0,    1,  32'hC000_000B, 0,  7);  // last stream resp
      set_vec(12, 0, 3'b111, 0,   1,    0,  32'h0,         0,  8);  // idle
      set_vec(13, 1, 3'b100, 0,   1,    1,  32'hA000_000D, 0,  8);  // multi-sel -> slave 0
      set_vec(14, 0, 3'b111, 0,   1,    0,  32'h0,         1,  9);  // flag set
      set_vec(15, 0, 3'b111, 1,   1,    0,  32'h0,         1,  9);  // clear alone
      set_vec(16, 1, 3'b001, 1,   1,    0,  32'h0,         0,  9);  // clear + multi -> slave 1
      set_vec(17, 0, 3'b111, 0,   0,    1,  32'hB000_0011, 1,  9);  // set won
      set_vec(18, 0, 3'b111, 0,   1,    0,  32'h0,         1, 10);  // idle
      set_vec(19, 1, 3'b111, 0,   1,    1,  32'hA000_0013, 1, 10);  // no cs -> default
      set_vec(20, 0, 3'b111, 0,   1,    0,  32'h0,         1, 11);  // idle

      // Reset state while rst is held.
      #2;
      check("reset_rd_valid", 32'(rd_valid), 32'h0);
      check("reset_rd_data", rd_data, 32'h0);
      check("reset_resp_cnt", 32'(resp_cnt), 32'h0);
      check("reset_err", 32'(multi_sel_err), 32'h0);
      check("reset_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      rst = 1'b0;

      // Table: drive just after the rising edge, check at the falling edge.
      for (int i = 0; i < 21; i++) begin
         @(posedge clk);
         #1;
         req_valid = vecs[i].rv;
         cs_n      = vecs[i].cs_n;
         err_clr   = vecs[i].clr;
         drive_data(i);
         @(negedge clk);
         check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
         check($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_vld));
         check($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_data);
         check($sformatf("v%0d_err", i), 32'(multi_sel_err), 32'(vecs[i].e_err));
         check($sformatf("v%0d_resp_cnt", i), 32'(resp_cnt), 32'(vecs[i].e_cnt));
      end

      // Reset mid-operation: lat1 accept to slave 2, then reset while its
      // response is on the return path.
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      cs_n      = 3'b011;
      err_clr   = 1'b0;
      @(negedge clk);
      check("rst_seq_accept", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cs_n      = 3'b111;
      #1;
      check("rst_seq_pending", 32'(rd_valid), 32'h1);
      rst = 1'b1;
      #1;
      check("rst_seq_rd_valid", 32'(rd_valid), 32'h0);
      check("rst_seq_rd_data", rd_data, 32'h0);
      check("rst_seq_cnt", 32'(resp_cnt), 32'h0);
      check("rst_seq_err", 32'(multi_sel_err), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d_rd_valid", k), 32'(rd_valid), 32'h0);
         check($sformatf("post_rst%0d_cnt", k), 32'(resp_cnt), 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
